// File: rtl/vga_pkg.sv
// Shared VGA constants: 640x480 timing, 3-bit {r,g,b} colours and the
// per-axis motion direction used by the bouncing box.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 521;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  // INC = right / down, DEC = left / up
  typedef enum logic {DIR_INC = 1'b0, DIR_DEC = 1'b1} dir_e;

endpackage

// File: rtl/vga_bounce_box_if.sv
// Pixel-stage bundle: timing counts and controls in, colour pins and box state out.
interface vga_bounce_box_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic [2:0]  switch;
  logic        run;
  logic        red;
  logic        green;
  logic        blue;
  logic        frame_tick;
  logic [9:0]  box_x;
  logic [9:0]  box_y;

  modport master (
    output hcount, vcount, switch, run,
    input  red, green, blue, frame_tick, box_x, box_y
  );

  modport slave (
    input  hcount, vcount, switch, run,
    output red, green, blue, frame_tick, box_x, box_y
  );
endinterface

// File: rtl/vga_bounce_box_axis.sv
// One axis of the bouncing box: position plus direction, stepped once per
// frame tick and clamped at 0 and LIMIT-SIZE, where the direction flips.
module bounce_axis
  import vga_pkg::*;
#(
  parameter int LIMIT     = 640,
  parameter int SIZE      = 32,
  parameter int STEP      = 2,
  parameter int RESET_POS = (LIMIT - SIZE) / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       run,
  output logic [9:0] pos,
  output dir_e       dir
);

  localparam logic [10:0] MAX_POS = 11'(LIMIT - SIZE);
  localparam logic [10:0] STEP_W  = 11'(STEP);

  logic [9:0]  pos_q, pos_d;
  dir_e        dir_q, dir_d;
  logic [10:0] pos_w;

  // 11-bit working copy so the sum against the wall cannot wrap
  assign pos_w = {1'b0, pos_q};

  always_comb begin
    pos_d = pos_q;
    dir_d = dir_q;
    if (tick && run) begin
      if (dir_q == DIR_INC) begin
        if (pos_w + STEP_W >= MAX_POS) begin
          pos_d = MAX_POS[9:0];
          dir_d = DIR_DEC;
        end else begin
          pos_d = 10'(pos_w + STEP_W);
        end
      end else begin
        if (pos_w <= STEP_W) begin
          pos_d = '0;
          dir_d = DIR_INC;
        end else begin
          pos_d = 10'(pos_w - STEP_W);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= 10'(RESET_POS);
      dir_q <= DIR_INC;
    end else begin
      pos_q <= pos_d;
      dir_q <= dir_d;
    end
  end

  assign pos = pos_q;
  assign dir = dir_q;

endmodule

// File: rtl/vga_bounce_box.sv
// Pixel-colour stage after the VGA timing generator: draws a solid square that
// moves diagonally once per frame and bounces off the active-area edges.
module vga_bounce_box #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic             clk,
  input  logic             rst,
  vga_bounce_box_if.slave  bus
);

  logic [9:0]     prev_vcount_q, prev_vcount_d;
  logic [2:0]     rgb_q, rgb_d;
  logic [9:0]     box_x, box_y;
  vga_pkg::dir_e  dx, dy;
  logic           frame_tick;
  logic           in_active, in_box;
  logic [10:0]    box_x_end, box_y_end;
  logic [2:0]     box_col;
  logic           unused_dir;

  // Edge of vcount into 0, so the generator's pixel-clock divider is irrelevant
  assign frame_tick    = (bus.vcount == 10'd0) && (prev_vcount_q != 10'd0);
  assign prev_vcount_d = bus.vcount;

  bounce_axis #(
    .LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP),
    .RESET_POS((H_ACTIVE - BOX_SIZE) / 2)
  ) u_axis_x (
    .clk(clk), .rst(rst), .tick(frame_tick), .run(bus.run),
    .pos(box_x), .dir(dx)
  );

  bounce_axis #(
    .LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(STEP),
    .RESET_POS((V_ACTIVE - BOX_SIZE) / 2)
  ) u_axis_y (
    .clk(clk), .rst(rst), .tick(frame_tick), .run(bus.run),
    .pos(box_y), .dir(dy)
  );

  assign unused_dir = (dx == vga_pkg::DIR_DEC) ^ (dy == vga_pkg::DIR_DEC);

  assign box_x_end = {1'b0, box_x} + 11'(BOX_SIZE);
  assign box_y_end = {1'b0, box_y} + 11'(BOX_SIZE);

  always_comb begin
    in_active = (bus.hcount < 11'(H_ACTIVE)) && (bus.vcount < 10'(V_ACTIVE));
    in_box    = (bus.hcount >= {1'b0, box_x}) && (bus.hcount < box_x_end) &&
                ({1'b0, bus.vcount} >= {1'b0, box_y}) &&
                ({1'b0, bus.vcount} < box_y_end);
    // An all-black selection would make the box invisible, so show white
    box_col   = (bus.switch == vga_pkg::BLACK) ? vga_pkg::WHITE : bus.switch;
    rgb_d     = (in_active && in_box) ? box_col : vga_pkg::BLACK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_vcount_q <= '0;
      rgb_q         <= vga_pkg::BLACK;
    end else begin
      prev_vcount_q <= prev_vcount_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.red        = rgb_q[2];
  assign bus.green      = rgb_q[1];
  assign bus.blue       = rgb_q[0];
  assign bus.frame_tick = frame_tick;
  assign bus.box_x      = box_x;
  assign bus.box_y      = box_y;

endmodule
